// File: rtl/dpad_conditioner.sv
// Conditions raw D-pad buttons and the move-enable switch into clean, conflict-resolved levels.
// Optional build macro: PAD_LAST_WINS_EN (most recently pressed direction wins per axis).
module dpad_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 650000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    input  logic       sw_move_raw,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       move_en,
    output logic [3:0] press_pulse
);

    localparam int unsigned N_IN  = 5;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned I_UP  = 3;
    localparam int unsigned I_DN  = 2;
    localparam int unsigned I_LF  = 1;
    localparam int unsigned I_RT  = 0;
    localparam int unsigned I_SW  = 4;

    // State encoding is {stable, pending}
    typedef enum logic [1:0] {
        ST_RELEASED   = 2'b00,
        ST_PRESS_PEND = 2'b01,
        ST_HELD       = 2'b10,
        ST_REL_PEND   = 2'b11
    } db_state_t;

    logic [N_IN-1:0] w_norm;
    logic [N_IN-1:0] r_sync1;
    logic [N_IN-1:0] r_sync2;
    logic [N_IN-1:0] w_stable;
    logic [3:0]      r_stable_d;

    logic w_up;
    logic w_dn;
    logic w_lf;
    logic w_rt;

    logic r_up;
    logic r_dn;
    logic r_lf;
    logic r_rt;
    logic r_move_en;
    logic [3:0] r_press;

    // Pressed is 1 from here on, whatever the pad polarity
    assign w_norm = {sw_move_raw, btn_raw} ^ {N_IN{ACTIVE_LOW}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_norm;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_db
        db_state_t        r_state;
        db_state_t        w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic [CNT_W-1:0] w_run;
        logic             w_done;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= ST_RELEASED;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // Length of the current run of synced samples that disagree with the stable level
        assign w_run  = r_state[0] ? (r_cnt + CNT_W'(1)) : CNT_W'(1);
        assign w_done = (w_run == CNT_W'(DEBOUNCE_CYCLES));

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = '0;
            case (r_state)
                ST_RELEASED, ST_PRESS_PEND: begin
                    if (r_sync2[gi]) begin
                        if (w_done) begin
                            w_state_nxt = ST_HELD;
                        end else begin
                            w_state_nxt = ST_PRESS_PEND;
                            w_cnt_nxt   = w_run;
                        end
                    end else begin
                        w_state_nxt = ST_RELEASED;
                    end
                end
                ST_HELD, ST_REL_PEND: begin
                    if (!r_sync2[gi]) begin
                        if (w_done) begin
                            w_state_nxt = ST_RELEASED;
                        end else begin
                            w_state_nxt = ST_REL_PEND;
                            w_cnt_nxt   = w_run;
                        end
                    end else begin
                        w_state_nxt = ST_HELD;
                    end
                end
                default: w_state_nxt = ST_RELEASED;
            endcase
        end

        assign w_stable[gi] = (r_state == ST_HELD) || (r_state == ST_REL_PEND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable_d <= '0;
        end else begin
            r_stable_d <= w_stable[3:0];
        end
    end

`ifdef PAD_LAST_WINS_EN
    // last: 0 = up/left rose most recently, 1 = down/right; tie = both rose together
    logic r_last_ud;
    logic r_last_lr;
    logic r_tie_ud;
    logic r_tie_lr;
    logic w_last_ud_nxt;
    logic w_last_lr_nxt;
    logic w_tie_ud_nxt;
    logic w_tie_lr_nxt;
    logic [3:0] w_rise;

    assign w_rise = w_stable[3:0] & ~r_stable_d;

    always_comb begin
        w_last_ud_nxt = r_last_ud;
        w_tie_ud_nxt  = r_tie_ud;
        w_last_lr_nxt = r_last_lr;
        w_tie_lr_nxt  = r_tie_lr;
        if (w_rise[I_UP] && w_rise[I_DN]) begin
            w_tie_ud_nxt = 1'b1;
        end else if (w_rise[I_UP] || w_rise[I_DN]) begin
            w_tie_ud_nxt  = 1'b0;
            w_last_ud_nxt = w_rise[I_DN];
        end
        if (w_rise[I_LF] && w_rise[I_RT]) begin
            w_tie_lr_nxt = 1'b1;
        end else if (w_rise[I_LF] || w_rise[I_RT]) begin
            w_tie_lr_nxt  = 1'b0;
            w_last_lr_nxt = w_rise[I_RT];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_ud <= 1'b0;
            r_last_lr <= 1'b0;
            r_tie_ud  <= 1'b0;
            r_tie_lr  <= 1'b0;
        end else begin
            r_last_ud <= w_last_ud_nxt;
            r_last_lr <= w_last_lr_nxt;
            r_tie_ud  <= w_tie_ud_nxt;
            r_tie_lr  <= w_tie_lr_nxt;
        end
    end

    always_comb begin
        w_up = w_stable[I_UP] & (~w_stable[I_DN] | (~w_tie_ud_nxt & ~w_last_ud_nxt));
        w_dn = w_stable[I_DN] & (~w_stable[I_UP] | (~w_tie_ud_nxt &  w_last_ud_nxt));
        w_lf = w_stable[I_LF] & (~w_stable[I_RT] | (~w_tie_lr_nxt & ~w_last_lr_nxt));
        w_rt = w_stable[I_RT] & (~w_stable[I_LF] | (~w_tie_lr_nxt &  w_last_lr_nxt));
    end
`else
    // Opposite directions held together cancel each other
    always_comb begin
        w_up = w_stable[I_UP] & ~w_stable[I_DN];
        w_dn = w_stable[I_DN] & ~w_stable[I_UP];
        w_lf = w_stable[I_LF] & ~w_stable[I_RT];
        w_rt = w_stable[I_RT] & ~w_stable[I_LF];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_up      <= 1'b0;
            r_dn      <= 1'b0;
            r_lf      <= 1'b0;
            r_rt      <= 1'b0;
            r_move_en <= 1'b0;
            r_press   <= '0;
        end else begin
            r_up      <= w_up;
            r_dn      <= w_dn;
            r_lf      <= w_lf;
            r_rt      <= w_rt;
            r_move_en <= w_stable[I_SW] & (w_up | w_dn | w_lf | w_rt);
            r_press   <= w_stable[3:0] & ~r_stable_d;
        end
    end

    assign up          = r_up;
    assign down        = r_dn;
    assign left        = r_lf;
    assign right       = r_rt;
    assign move_en     = r_move_en;
    assign press_pulse = r_press;

endmodule

// File: tb/tb_dpad_conditioner.sv
// Bench for dpad_conditioner: directed scenarios plus random bouncing checked every cycle
// against a window-based reference model (honours PAD_LAST_WINS_EN when defined).
module tb_dpad_conditioner;

    localparam int D = 8;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic       sw;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       move_en;
    logic [3:0] press_pulse;

    int n_total = 0;
    int n_bad   = 0;

    dpad_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn),
        .sw_move_raw(sw),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .move_en    (move_en),
        .press_pulse(press_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a level is accepted once the last D synchronised samples all disagree with it
    bit        m_live = 1'b0;
    bit        m_hist [5][D+1];
    bit [4:0]  m_stable;
    bit [4:0]  m_stable_old;
    longint    m_rise [4];
    longint    cyc = 0;
    logic [8:0] exp_vec;
    bit [4:0]  norm;
    bit [3:0]  o;
    bit        all_diff;

    function automatic bit resolve(input bit a, input bit b, input longint ta, input longint tb_t);
`ifdef PAD_LAST_WINS_EN
        return a && (!b || ta > tb_t);
`else
        return a && !b;
`endif
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_live       = 1'b1;
            m_stable     = '0;
            m_stable_old = '0;
            for (int i = 0; i < 5; i++)
                for (int k = 0; k <= D; k++) m_hist[i][k] = 1'b0;
            for (int i = 0; i < 4; i++) m_rise[i] = 0;
            exp_vec = '0;
        end else begin
            o[3] = resolve(m_stable[3], m_stable[2], m_rise[3], m_rise[2]);
            o[2] = resolve(m_stable[2], m_stable[3], m_rise[2], m_rise[3]);
            o[1] = resolve(m_stable[1], m_stable[0], m_rise[1], m_rise[0]);
            o[0] = resolve(m_stable[0], m_stable[1], m_rise[0], m_rise[1]);
            exp_vec = {o, m_stable[4] && (o != 4'b0), m_stable[3:0] & ~m_stable_old[3:0]};
            m_stable_old = m_stable;
            norm = ~{sw, btn};
            for (int i = 0; i < 5; i++) begin
                all_diff = 1'b1;
                for (int k = 1; k <= D; k++)
                    if (m_hist[i][k] == m_stable[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_stable[i] = ~m_stable[i];
                    if (i < 4 && m_stable[i]) m_rise[i] = cyc;
                end
                for (int k = D; k >= 1; k--) m_hist[i][k] = m_hist[i][k-1];
                m_hist[i][0] = norm[i];
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) check("model", {23'b0, up, down, left, right, move_en, press_pulse}, {23'b0, exp_vec});
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    logic acc;

    initial begin
        rst = 1'b1;
        btn = 4'hF;
        sw  = 1'b1;
        step(3);
        check("reset_outs", {23'b0, up, down, left, right, move_en, press_pulse}, 32'd0);
        rst = 1'b0;
        step(1);

        // single press latency and pulse
        btn[3] = 1'b0;
        step(10);
        check("up_early", {31'b0, up}, 32'd0);
        step(1);
        check("up_lat", {31'b0, up}, 32'd1);
        check("pulse_up", {28'b0, press_pulse}, 32'h8);
        step(1);
        check("pulse_one", {28'b0, press_pulse}, 32'h0);
        btn = 4'hF;
        step(11);
        check("up_release", {31'b0, up}, 32'd0);

        // bounce shorter than the debounce window
        acc = 1'b0;
        for (int c = 0; c < 40; c++) begin
            btn[3] = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
            step(1);
            acc = acc | up | press_pulse[3];
        end
        btn = 4'hF;
        for (int c = 0; c < 12; c++) begin
            step(1);
            acc = acc | up | press_pulse[3];
        end
        check("bounce", {31'b0, acc}, 32'd0);

        // opposite directions on one axis
        btn[3] = 1'b0;
        step(20);
        btn[2] = 1'b0;
        step(10);
        check("ud_before", {30'b0, up, down}, 32'b10);
        step(1);
`ifdef PAD_LAST_WINS_EN
        check("ud_conflict", {30'b0, up, down}, 32'b01);
`else
        check("ud_conflict", {30'b0, up, down}, 32'b00);
`endif
        btn[2] = 1'b1;
        step(11);
        check("ud_after_rel", {30'b0, up, down}, 32'b10);
        btn = 4'hF;
        step(12);

        // switch gating move_en
        sw     = 1'b0;
        btn[1] = 1'b0;
        step(11);
        check("move_on", {30'b0, left, move_en}, 32'b11);
        sw = 1'b1;
        step(10);
        check("move_hold", {31'b0, move_en}, 32'd1);
        step(1);
        check("move_off", {30'b0, left, move_en}, 32'b10);
        btn = 4'hF;
        step(12);

        // reset mid-debounce restarts the full latency
        btn[0] = 1'b0;
        step(5);
        rst = 1'b1;
        step(1);
        check("rst_mid", {31'b0, right}, 32'd0);
        rst = 1'b0;
        step(10);
        check("rt_early", {31'b0, right}, 32'd0);
        step(1);
        check("rt_lat", {31'b0, right}, 32'd1);
        btn = 4'hF;
        step(12);

        // diagonal press
        sw     = 1'b0;
        btn[3] = 1'b0;
        btn[1] = 1'b0;
        step(11);
        check("diag_dirs", {28'b0, up, down, left, right}, 32'b1010);
        check("diag_pulse", {28'b0, press_pulse}, 32'b1010);
        check("diag_move", {31'b0, move_en}, 32'd1);
        step(1);
        check("diag_pulse_end", {28'b0, press_pulse}, 32'd0);
        sw = 1'b1;
        step(11);
        check("diag_move_off", {31'b0, move_en}, 32'd0);
        btn = 4'hF;
        step(12);

        // random bouncing with occasional reset
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 11) == 0) btn[i] = ~btn[i];
            if ($urandom_range(0, 11) == 0) sw = ~sw;
            rst = ($urandom_range(0, 299) == 0);
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
